// File: rtl/bcd_to_binary_converter.sv
// Three-digit BCD to 10-bit binary converter using reverse double-dabble.
// One shift/correct step per clock; ten steps per conversion.
//
// state | meaning
// IDLE  | waiting for start; outputs hold their last values
// CONV  | shifting {bcd, bin_sr} right and correcting BCD digits, 10 cycles
// DONE  | one-cycle completion pulse, bin/err valid
module bcd_to_binary_converter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [9:0] bin,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state_q, state_d;
    logic [11:0] bcd_q, bcd_d;
    logic [9:0]  bin_sr_q, bin_sr_d;
    logic [9:0]  bin_q, bin_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        digits_ok;
    logic [21:0] shifted;
    logic [11:0] bcd_adj;

    // A digit that landed at 8 or above after the shift owes 3 (half of the
    // decimal-to-binary carry difference of 6).
    function automatic logic [3:0] adj(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    always_comb begin
        digits_ok = (hundreds <= 4'd9) && (tens <= 4'd9) && (ones <= 4'd9);
        shifted   = {bcd_q, bin_sr_q} >> 1;
        bcd_adj   = {adj(shifted[21:18]), adj(shifted[17:14]), adj(shifted[13:10])};
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_sr_d = bin_sr_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (digits_ok) begin
                        bcd_d    = {hundreds, tens, ones};
                        bin_sr_d = 10'd0;
                        cnt_d    = 4'd0;
                        state_d  = CONV;
                    end else begin
                        bin_d   = 10'd0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CONV: begin
                bcd_d    = bcd_adj;
                bin_sr_d = shifted[9:0];
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    bin_d   = shifted[9:0];
                    err_d   = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bcd_q    <= 12'd0;
            bin_sr_q <= 10'd0;
            bin_q    <= 10'd0;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_sr_q <= bin_sr_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign bin  = bin_q;
    assign err  = err_q;
    assign busy = (state_q == CONV);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Self-checking bench for bcd_to_binary_converter: directed cases plus a full
// 0-999 sweep with random gaps and digit churn, checked against decimal arithmetic.
module tb_bcd_to_binary_converter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [9:0] bin;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int runs     = 0;
    int done_cnt = 0;

    bcd_to_binary_converter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: quiet; mode 1: re-assert start with 0-1-1 during CONV and DONE;
    // mode 2: random digit churn during CONV with start low.
    task automatic run(input int h, input int t, input int o, input int mode);
        int lat;
        int bcnt;
        int expv;
        bit e;
        e    = (h > 9) || (t > 9) || (o > 9);
        expv = e ? 0 : 100 * h + 10 * t + o;
        hundreds = 4'(h);
        tens     = 4'(t);
        ones     = 4'(o);
        start    = 1'b1;
        tick();
        start = 1'b0;
        runs++;
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 30) begin
            bcnt += int'(busy);
            if (mode == 1) begin
                start    = 1'b1;
                hundreds = 4'd0;
                tens     = 4'd1;
                ones     = 4'd1;
            end else if (mode == 2) begin
                hundreds = 4'($urandom_range(0, 15));
                tens     = 4'($urandom_range(0, 15));
                ones     = 4'($urandom_range(0, 15));
            end
            tick();
            lat++;
        end
        chk("latency", 32'(lat), e ? 32'd1 : 32'd11);
        chk("busy_cycles", 32'(bcnt), e ? 32'd0 : 32'd10);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("err", 32'(err), 32'(e));
        chk("bin", 32'(bin), 32'(expv));
        tick();
        chk("done_width", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("bin_hold", 32'(bin), 32'(expv));
        chk("err_hold", 32'(err), 32'(e));
        start = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;
        repeat (2) tick();
        chk("rst_bin", 32'(bin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        run(2, 5, 5, 0);
        run(0, 0, 0, 0);
        run(1, 10, 3, 0);
        run(9, 9, 9, 0);

        // Abort a conversion mid-flight with reset.
        hundreds = 4'd4;
        tens     = 4'd5;
        ones     = 4'd6;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort_bin", 32'(bin), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end
        run(1, 2, 8, 0);

        // Ignored starts during CONV/DONE, then back-to-back accept.
        run(3, 0, 7, 1);
        run(0, 1, 1, 0);

        for (int v = 0; v < 1000; v++) begin
            repeat ($urandom_range(0, 3)) tick();
            run(v / 100, (v / 10) % 10, v % 10, 2);
        end

        for (int i = 0; i < 8; i++) begin
            run($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(10, 15), 0);
            run(9, 9, 9, 0);
        end

        chk("done_pulses", 32'(done_cnt), 32'(runs));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_converter.md
BCD_TO_BINARY_CONVERTER -- requirements
Module: bcd_to_binary_converter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (3 BCD digits in, 10-bit binary out).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to convert; sampled only in IDLE.
REQ-005 hundreds  input  4  BCD hundreds digit, legal 0-9.
REQ-006 tens  input  4  BCD tens digit, legal 0-9.
REQ-007 ones  input  4  BCD ones digit, legal 0-9.
REQ-008 bin  output  10  binary result, registered, held until next accepted start.
REQ-009 busy  output  1  high while a conversion is in progress (CONV state).
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  invalid-digit flag, valid while done is high.

Function
REQ-012 States SHALL be IDLE, CONV and DONE; reset and power-up state is IDLE.
REQ-013 IDLE: start=1 with all digits <=9 SHALL latch {hundreds,tens,ones} into a 12-bit BCD shift register, clear a 10-bit binary shift register, clear a 4-bit iteration counter and go to CONV.
REQ-014 IDLE: start=1 with any digit >9 SHALL go to DONE with err=1 and bin=0 on the next edge (no CONV cycles).
REQ-015 IDLE with start=0 SHALL hold all outputs unchanged.
REQ-016 CONV: each cycle SHALL shift the concatenation {bcd,bin_sr} right by 1, then subtract 3 from each 4-bit BCD digit whose post-shift value is >=8 (reverse double-dabble).
REQ-017 CONV SHALL run exactly 10 iterations (counter 0..9); on the 10th edge, bin SHALL load bin_sr, err SHALL clear and the state SHALL become DONE.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+10 and low again after edge k+11; error path: done high after edge k+1.
REQ-019 busy SHALL be high exactly in CONV cycles (10 cycles for a valid start, 0 for an invalid start).
REQ-020 DONE SHALL last one cycle, then go to IDLE unconditionally; start during DONE or CONV SHALL be ignored (not queued).
REQ-021 Input digits SHALL NOT be sampled after the accept edge; changes during CONV do not affect the result.
REQ-022 bin SHALL change only on the final CONV edge or on the error-path edge; it SHALL equal 100*hundreds + 10*tens + ones (range 0-999) after a valid conversion.
REQ-023 err SHALL remain at its last value until the next accepted start; done SHALL never be high for two consecutive cycles.
REQ-024 Back-to-back: a start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a minimum start-to-start spacing of 12 cycles.

Reset
REQ-025 rst_n=0 at any rising edge SHALL force state IDLE, bin=0, busy=0, done=0, err=0, counter=0 and clear both shift registers, including in the middle of CONV; no done pulse SHALL follow a reset-aborted conversion.
REQ-026 After rst_n returns high, the first start SHALL be accepted on the first edge it is sampled high.

Verification
REQ-027 h=2,t=5,o=5, 1-cycle start -> busy high for 10 cycles, then done=1, err=0, bin=255 (0x0FF).
REQ-028 h=9,t=9,o=9 -> bin=999 (0x3E7), err=0; h=0,t=0,o=0 -> bin=0, done pulse still produced after 11 edges.
REQ-029 h=1,t=0xA,o=3, start -> done high after edge k+1, err=1, bin=0, busy never high.
REQ-030 Start 4-5-6, rst_n low at CONV iteration 5 -> all outputs 0 the next cycle; no done; then start 1-2-8 -> bin=128.
REQ-031 Start 3-0-7, re-assert start with 0-1-1 during CONV and during DONE -> both ignored, bin=307; start in the next IDLE cycle -> bin=11 after 11 edges.
REQ-032 Exhaustive 0-999 sweep with a randomized idle gap of 0-3 cycles and digit changes during CONV -> every bin matches the decimal value; done-pulse count equals the number of accepted starts.
